// File: rtl/abr_sync_pkg.sv
// abr_sync_pkg: shared constants and filter state type for the abr_sync_filter slice
package abr_sync_pkg;

    localparam int ABR_SYNC_MIN_STAGES   = 2;
    localparam int ABR_SYNC_GLITCH_CNT_W = 8;

    typedef enum logic {SYNC_IDLE, SYNC_QUAL} sync_state_e;

endpackage

// File: rtl/abr_sync_filt_chan.sv
// abr_sync_filt_chan: one channel: flop chain, optional stability filter, edge pulses
// The glitch output exists only when ABR_SYNC_FILTER_GLITCH_CNT_EN is defined.
module abr_sync_filt_chan #(
    parameter int   STAGES      = 2,
    parameter logic RST_VAL     = 1'b0,
    parameter int   FILT_CYCLES = 0
) (
    input  logic clk,
    input  logic rst_b,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
`ifdef ABR_SYNC_FILTER_GLITCH_CNT_EN
    ,
    output logic glitch
`endif
);
    import abr_sync_pkg::*;

    logic [STAGES-1:0] stg;
    logic              s;
    logic              dout_d;

    assign s = stg[STAGES-1];

    // synchroniser chain, din enters at stage 0
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) stg <= {STAGES{RST_VAL}};
        else        stg <= {stg[STAGES-2:0], din};
    end

    generate
        if (FILT_CYCLES == 0) begin : g_nofilt
            assign dout = s;
`ifdef ABR_SYNC_FILTER_GLITCH_CNT_EN
            assign glitch = 1'b0;
`endif
        end else begin : g_filt
            localparam int            CW   = $clog2(FILT_CYCLES + 1);
            localparam logic [CW-1:0] LAST = CW'(FILT_CYCLES - 1);

            sync_state_e   state, state_nxt;
            logic [CW-1:0] cnt, cnt_nxt;
            logic          dout_nxt;

            // filter state, qualification counter and filtered level
            always_ff @(posedge clk or negedge rst_b) begin
                if (!rst_b) begin
                    state <= SYNC_IDLE;
                    cnt   <= '0;
                    dout  <= RST_VAL;
                end else begin
                    state <= state_nxt;
                    cnt   <= cnt_nxt;
                    dout  <= dout_nxt;
                end
            end

            // dout follows s only after s differs from dout for FILT_CYCLES cycles
            always_comb begin
                state_nxt = state;
                cnt_nxt   = cnt;
                dout_nxt  = dout;
                if (state == SYNC_IDLE) begin
                    if (s != dout) begin
                        if (FILT_CYCLES == 1) begin
                            dout_nxt = s;
                        end else begin
                            state_nxt = SYNC_QUAL;
                            cnt_nxt   = CW'(1);
                        end
                    end
                end else begin
                    if (s == dout) begin
                        state_nxt = SYNC_IDLE;
                        cnt_nxt   = '0;
                    end else if (cnt == LAST) begin
                        state_nxt = SYNC_IDLE;
                        cnt_nxt   = '0;
                        dout_nxt  = s;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end

`ifdef ABR_SYNC_FILTER_GLITCH_CNT_EN
            // a qualification abandoned because s fell back to dout
            assign glitch = (state == SYNC_QUAL) && (s == dout);
`endif
        end
    endgenerate

    // previous dout for edge detection
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) dout_d <= RST_VAL;
        else        dout_d <= dout;
    end

    assign rise = dout & ~dout_d;
    assign fall = ~dout & dout_d;

endmodule

// File: rtl/abr_sync_filter.sv
// abr_sync_filter: multi-bit synchroniser with optional glitch filter and edge pulses
// Defining ABR_SYNC_FILTER_GLITCH_CNT_EN adds glitch_clr/glitch_cnt, a saturating reject counter.
module abr_sync_filter
    import abr_sync_pkg::*;
#(
    parameter int               WIDTH       = 1,
    parameter int               STAGES      = 2,
    parameter logic [WIDTH-1:0] RST_VAL     = '0,
    parameter int               FILT_CYCLES = 0
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
`ifdef ABR_SYNC_FILTER_GLITCH_CNT_EN
    ,
    input  logic                             glitch_clr,
    output logic [ABR_SYNC_GLITCH_CNT_W-1:0] glitch_cnt
`endif
);

    generate
        if (STAGES < ABR_SYNC_MIN_STAGES) begin : g_bad_stages
            $error("abr_sync_filter: STAGES must be >= %0d", ABR_SYNC_MIN_STAGES);
        end
    endgenerate

`ifdef ABR_SYNC_FILTER_GLITCH_CNT_EN
    logic [WIDTH-1:0] glitch;
`endif

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_chan
            abr_sync_filt_chan #(
                .STAGES      (STAGES),
                .RST_VAL     (RST_VAL[i]),
                .FILT_CYCLES (FILT_CYCLES)
            ) u_chan (
                .clk    (clk),
                .rst_b  (rst_b),
                .din    (din[i]),
                .dout   (dout[i]),
                .rise   (rise[i]),
                .fall   (fall[i])
`ifdef ABR_SYNC_FILTER_GLITCH_CNT_EN
                ,
                .glitch (glitch[i])
`endif
            );
        end
    endgenerate

`ifdef ABR_SYNC_FILTER_GLITCH_CNT_EN
    // one count per cycle with any rejected glitch; clear wins, saturates at all-ones
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b)                          glitch_cnt <= '0;
        else if (glitch_clr)                 glitch_cnt <= '0;
        else if (|glitch && ~&glitch_cnt)    glitch_cnt <= glitch_cnt + 1'b1;
    end
`endif

endmodule

// File: tb/tb_abr_sync_filter.sv
// tb_abr_sync_filter: directed checks of reset, latency, filtering and edge pulses
module tb_abr_sync_filter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, rst_b_, rst_c, rst_d;
    logic [3:0] din_a, dout_a, rise_a, fall_a;
    logic       din_b, dout_b, rise_b, fall_b;
    logic       din_c, dout_c, rise_c, fall_c;
    logic       din_d, dout_d, rise_d, fall_d;
    logic       clr;
    logic [7:0] gc_a, gc_b, gc_c, gc_d;
    logic [2:0] seen;

    int total = 0;
    int bad   = 0;

    abr_sync_filter #(.WIDTH(4), .STAGES(2), .RST_VAL(4'b1010), .FILT_CYCLES(0)) u_a (
        .clk(clk), .rst_b(rst_a), .din(din_a), .dout(dout_a), .rise(rise_a), .fall(fall_a)
`ifdef ABR_SYNC_FILTER_GLITCH_CNT_EN
        , .glitch_clr(clr), .glitch_cnt(gc_a)
`endif
    );

    abr_sync_filter #(.WIDTH(1), .STAGES(3), .RST_VAL(1'b0), .FILT_CYCLES(0)) u_b (
        .clk(clk), .rst_b(rst_b_), .din(din_b), .dout(dout_b), .rise(rise_b), .fall(fall_b)
`ifdef ABR_SYNC_FILTER_GLITCH_CNT_EN
        , .glitch_clr(clr), .glitch_cnt(gc_b)
`endif
    );

    abr_sync_filter #(.WIDTH(1), .STAGES(2), .RST_VAL(1'b0), .FILT_CYCLES(4)) u_c (
        .clk(clk), .rst_b(rst_c), .din(din_c), .dout(dout_c), .rise(rise_c), .fall(fall_c)
`ifdef ABR_SYNC_FILTER_GLITCH_CNT_EN
        , .glitch_clr(clr), .glitch_cnt(gc_c)
`endif
    );

    abr_sync_filter #(.WIDTH(1), .STAGES(2), .RST_VAL(1'b0), .FILT_CYCLES(8)) u_d (
        .clk(clk), .rst_b(rst_d), .din(din_d), .dout(dout_d), .rise(rise_d), .fall(fall_d)
`ifdef ABR_SYNC_FILTER_GLITCH_CNT_EN
        , .glitch_clr(clr), .glitch_cnt(gc_d)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst_a = 1'b0; rst_b_ = 1'b0; rst_c = 1'b0; rst_d = 1'b0;
        din_a = 4'b0101; din_b = 1'b0; din_c = 1'b0; din_d = 1'b0;
        clr = 1'b0;
        tick(3);
        chk("a_rst_dout", 32'(dout_a), 32'ha);
        chk("a_rst_rise", 32'(rise_a), 32'h0);
        chk("a_rst_fall", 32'(fall_a), 32'h0);
        chk("c_rst_dout", 32'(dout_c), 32'h0);
        rst_a = 1'b1; rst_b_ = 1'b1; rst_c = 1'b1; rst_d = 1'b1;
        tick(1);
        chk("a_rel_e1_dout", 32'(dout_a), 32'ha);
        tick(1);
        chk("a_rel_e2_dout", 32'(dout_a), 32'h5);
        chk("a_rel_e2_rise", 32'(rise_a), 32'h5);
        chk("a_rel_e2_fall", 32'(fall_a), 32'ha);
        tick(1);
        chk("a_rel_e3_rise", 32'(rise_a), 32'h0);
        chk("a_rel_e3_fall", 32'(fall_a), 32'h0);
        din_a = 4'b0110;
        tick(1);
        chk("a_mix_e1_dout", 32'(dout_a), 32'h5);
        tick(1);
        chk("a_mix_e2_dout", 32'(dout_a), 32'h6);
        chk("a_mix_e2_rise", 32'(rise_a), 32'h2);
        chk("a_mix_e2_fall", 32'(fall_a), 32'h1);

        din_b = 1'b1;
        tick(2);
        chk("b_e2_dout", 32'(dout_b), 32'h0);
        tick(1);
        chk("b_e3_dout", 32'(dout_b), 32'h1);
        chk("b_e3_rise", 32'(rise_b), 32'h1);
        tick(1);
        chk("b_e4_rise", 32'(rise_b), 32'h0);
`ifdef ABR_SYNC_FILTER_GLITCH_CNT_EN
        chk("b_gcnt", 32'(gc_b), 32'h0);
`endif

        seen = '0;
        din_c = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (i == 3) din_c = 1'b0;
            tick(1);
            seen = seen | {dout_c, rise_c, fall_c};
        end
        chk("c_reject", 32'(seen), 32'h0);
`ifdef ABR_SYNC_FILTER_GLITCH_CNT_EN
        chk("c_reject_gcnt", 32'(gc_c), 32'h1);
`endif
        din_c = 1'b1;
        tick(5);
        chk("c_pass_e5_dout", 32'(dout_c), 32'h0);
        tick(1);
        chk("c_pass_e6_dout", 32'(dout_c), 32'h1);
        chk("c_pass_e6_rise", 32'(rise_c), 32'h1);
        tick(1);
        chk("c_pass_e7_rise", 32'(rise_c), 32'h0);
        din_c = 1'b0;
        tick(5);
        chk("c_fall_e5_dout", 32'(dout_c), 32'h1);
        tick(1);
        chk("c_fall_e6_dout", 32'(dout_c), 32'h0);
        chk("c_fall_e6_fall", 32'(fall_c), 32'h1);
        tick(2);

`ifdef ABR_SYNC_FILTER_GLITCH_CNT_EN
        for (int g = 0; g < 300; g++) begin
            din_c = 1'b1;
            tick(1);
            din_c = 1'b0;
            tick(5);
        end
        chk("c_sat_gcnt", 32'(gc_c), 32'd255);
        chk("c_sat_dout", 32'(dout_c), 32'h0);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        chk("c_clr_gcnt", 32'(gc_c), 32'h0);
        din_c = 1'b1;
        tick(1);
        din_c = 1'b0;
        tick(2);
        chk("c_glitch_e3_gcnt", 32'(gc_c), 32'h0);
        tick(1);
        chk("c_glitch_e4_gcnt", 32'(gc_c), 32'h1);
        tick(2);
        din_c = 1'b1;
        tick(1);
        din_c = 1'b0;
        tick(2);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        chk("c_clr_wins_gcnt", 32'(gc_c), 32'h0);
        tick(3);
        chk("c_after_clr_gcnt", 32'(gc_c), 32'h0);
`endif

        din_d = 1'b1;
        tick(7);
        chk("d_qual_dout", 32'(dout_d), 32'h0);
        rst_d = 1'b0;
        #1;
        chk("d_rst_dout", 32'(dout_d), 32'h0);
        chk("d_rst_pulse", 32'({rise_d, fall_d}), 32'h0);
        din_d = 1'b0;
        tick(2);
        rst_d = 1'b1;
        seen = '0;
        for (int i = 0; i < 15; i++) begin
            tick(1);
            seen = seen | {dout_d, rise_d, fall_d};
        end
        chk("d_post_rst_quiet", 32'(seen), 32'h0);
        din_d = 1'b1;
        tick(9);
        chk("d_pass_e9_dout", 32'(dout_d), 32'h0);
        tick(1);
        chk("d_pass_e10_dout", 32'(dout_d), 32'h1);
        chk("d_pass_e10_rise", 32'(rise_d), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/abr_sync_filter.md
Name: abr_sync_filter

Overview:
- Parametrised multi-bit, N-stage synchroniser for asynchronous level inputs entering the clk domain.
- Each bit has a configurable-depth flop chain, an optional stability (glitch) filter and one-cycle rise/fall event pulses.
- Sits at every asynchronous control/status input of a crypto core, such as straps, external enables and interrupt levels.
- Bits are independent. Multi-bit buses get no coherency guarantee.

Parameters:
- WIDTH, 1: number of independent channels.
- STAGES, 2: synchroniser depth. Must be >= 2; a smaller value is an elaboration error.
- RST_VAL, '0 (WIDTH bits): per-bit reset value of every chain flop, dout and the edge-detect flop.
- FILT_CYCLES, 0: stability window in clk cycles. 0 disables the filter.

Ports:
- clk  in  1  clock
- rst_b  in  1  reset, asynchronous, active-low
- din  in  WIDTH  asynchronous input levels
- dout  out  WIDTH  synchronised, filtered levels
- rise  out  WIDTH  one-cycle pulse: dout bit went 0->1
- fall  out  WIDTH  one-cycle pulse: dout bit went 1->0
- glitch_clr  in  1  synchronous clear of glitch_cnt (present only with the macro)
- glitch_cnt  out  8  saturating glitch-reject count (present only with the macro)

Behaviour:
- Reset values:
  - All chain flops, dout and dout_d (edge-detect flop) = RST_VAL.
  - Filter counters = 0.
  - rise and fall = 0.
  - glitch_cnt = 0.
- Chain: stage[0] <= din; stage[k] <= stage[k-1]. Call the last stage s.
- Latency din->s: STAGES clk edges.
- FILT_CYCLES == 0: dout = s, no extra flop. Total latency is STAGES.
- FILT_CYCLES = N >= 1: per-channel 2-state FSM, counter width clog2(N+1).
  - IDLE (cnt=0): if s == dout, stay. If s != dout, go to QUAL with cnt <= 1, except when N == 1: then dout <= s and remain IDLE.
  - QUAL, s == dout (glitch): cnt <= 0, go to IDLE, dout unchanged, glitch event asserted.
  - QUAL, s != dout and cnt == N-1: dout <= s, cnt <= 0, go to IDLE.
  - QUAL, otherwise: cnt <= cnt+1.
  - Result: dout follows s only after s has differed from dout for N consecutive cycles. Latency din->dout is STAGES+N.
  - A pulse shorter than N cycles at s never reaches dout.
- Edge pulses:
  - dout_d <= dout every cycle.
  - rise = dout & ~dout_d; fall = ~dout & dout_d. Both are combinational off flops.
  - Each pulse lasts exactly one cycle per dout transition. None are generated out of reset.
- Channels never interact. Simultaneous transitions on several bits give simultaneous per-bit pulses.
- Reset mid-qualification: counters drop to 0 and dout returns to RST_VAL. The pending transition is lost, and no pulse is generated at reset release.
- din held constant at RST_VAL through and after reset: no rise/fall ever.

Optional Feature:
- Macro: ABR_SYNC_FILTER_GLITCH_CNT_EN.
- When defined:
  - glitch_clr and glitch_cnt ports exist.
  - glitch_cnt increments by 1 in any cycle where at least one channel takes the QUAL->IDLE glitch transition. Several channels in the same cycle still count as 1.
  - glitch_cnt saturates at 255.
  - glitch_clr forces 0 and wins over a same-cycle increment.
  - With FILT_CYCLES == 0, glitch_cnt is constant 0.
- When undefined: ports absent, no counter logic.

Decomposition:
- Package abr_sync_pkg holds:
  - ABR_SYNC_MIN_STAGES = 2
  - ABR_SYNC_GLITCH_CNT_W = 8
  - a typedef enum logic {SYNC_IDLE, SYNC_QUAL} for the filter state.
- Sub-module abr_sync_filt_chan holds one channel (chain, filter FSM, edge detect, glitch event output). It is instantiated WIDTH times in a generate loop.
- The top level ORs the glitch events and holds the optional counter.

Test Plan:
- Reset values: WIDTH=4, RST_VAL=4'b1010, reset held, din=4'b0101 -> dout=4'b1010, rise=fall=0. After release, dout=4'b0101 exactly 2 edges later; rise[0], rise[2], fall[1], fall[3] each high for one cycle.
- Depth and latency: STAGES=3, FILT_CYCLES=0, din[0] 0->1 -> dout[0] high after 3 edges, single rise[0] pulse.
- Filter reject: STAGES=2, FILT_CYCLES=4, din pulse of 3 cycles -> dout stays 0, no pulses. With the macro, glitch_cnt=1.
- Filter pass: same configuration, din held for 4+ cycles -> dout rises exactly 6 edges after the din change, one rise pulse.
- Saturation and clear (macro): 300 short glitches -> glitch_cnt=255. glitch_clr together with a glitch in the same cycle -> glitch_cnt=0.
- Reset mid-qualification: FILT_CYCLES=8, assert rst_b at cnt=5 -> dout=RST_VAL, cnt=0, no pulse after release while din equals RST_VAL.
